// File: rtl/usb_dev_responder.sv
// usb_dev_responder
// Device-side USB transaction responder. Answers decoded OUT and IN tokens
// addressed to this device: OUT payloads are delivered to the endpoint sink
// and acknowledged; IN payloads are sent from the endpoint source and
// retransmitted until the host ACKs or the retry budget runs out.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   tok_valid/pid/addr/endp        decoded token packet (one-cycle strobe)
//   dat_valid/pid/corrupt, dat_in  decoded data packet (one-cycle strobe)
//   hs_valid, hs_pid               decoded handshake packet (one-cycle strobe)
//   tx_ready, tx_valid/type/pid/data  packet request to the encoder
//   wr_valid/endp/data             OUT payload delivered to the sink
//   rd_avail, rd_data, rd_pop      IN payload source
//   busy                           transaction in progress
//   err                            transaction aborted (one-cycle strobe)

module usb_dev_responder #(
    parameter logic [6:0] DEV_ADDR  = 7'd5,
    parameter logic [7:0] TIMEOUT   = 8'd255,
    parameter logic [3:0] MAX_RETRY = 4'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tok_valid,
    input  logic [3:0]  tok_pid,
    input  logic [6:0]  tok_addr,
    input  logic [3:0]  tok_endp,
    input  logic        dat_valid,
    input  logic [3:0]  dat_pid,
    input  logic        dat_corrupt,
    input  logic [63:0] dat_in,
    input  logic        hs_valid,
    input  logic [3:0]  hs_pid,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic        tx_type,
    output logic [3:0]  tx_pid,
    output logic [63:0] tx_data,
    output logic        wr_valid,
    output logic [3:0]  wr_endp,
    output logic [63:0] wr_data,
    input  logic        rd_avail,
    input  logic [63:0] rd_data,
    output logic        rd_pop,
    output logic        busy,
    output logic        err
);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    typedef enum logic [2:0] {
        IDLE,
        RX_DATA,
        TX_HS,
        TX_DATA,
        WAIT_HS
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  endp_q, endp_d;
    logic [63:0] payload_q, payload_d;
    logic [3:0]  hs_pid_q, hs_pid_d;
    logic [7:0]  timer_q, timer_d;
    logic [3:0]  retry_q, retry_d;
    // After a handshake is sent: 1 = go back to RX_DATA (host resends), 0 = IDLE
    logic        hs_ret_rx_q, hs_ret_rx_d;

    logic        timeout;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            endp_q      <= 4'd0;
            payload_q   <= 64'd0;
            hs_pid_q    <= 4'd0;
            timer_q     <= 8'd0;
            retry_q     <= 4'd0;
            hs_ret_rx_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            endp_q      <= endp_d;
            payload_q   <= payload_d;
            hs_pid_q    <= hs_pid_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            hs_ret_rx_q <= hs_ret_rx_d;
        end
    end

    assign timeout = (timer_q == TIMEOUT);

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        endp_d      = endp_q;
        payload_d   = payload_q;
        hs_pid_d    = hs_pid_q;
        timer_d     = timer_q;
        retry_d     = retry_q;
        hs_ret_rx_d = hs_ret_rx_q;

        tx_valid = 1'b0;
        tx_type  = 1'b0;
        tx_pid   = 4'd0;
        tx_data  = 64'd0;
        wr_valid = 1'b0;
        wr_endp  = 4'd0;
        wr_data  = 64'd0;
        rd_pop   = 1'b0;
        err      = 1'b0;
        busy     = (state_q != IDLE);

        // The wait timer runs only while listening for the host; it saturates
        // so the timeout condition stays asserted until the state is left.
        if ((state_q == RX_DATA || state_q == WAIT_HS) && !timeout) begin
            timer_d = timer_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (tok_valid && tok_addr == DEV_ADDR) begin
                    if (tok_pid == PID_OUT) begin
                        endp_d  = tok_endp;
                        timer_d = 8'd0;
                        state_d = RX_DATA;
                    end else if (tok_pid == PID_IN) begin
                        if (rd_avail) begin
                            payload_d = rd_data;
                            endp_d    = tok_endp;
                            timer_d   = 8'd0;
                            retry_d   = 4'd0;
                            state_d   = TX_DATA;
                        end else begin
                            hs_pid_d    = PID_NAK;
                            hs_ret_rx_d = 1'b0;
                            state_d     = TX_HS;
                        end
                    end
                end
            end

            RX_DATA: begin
                // Data arriving on the timeout cycle still wins.
                if (dat_valid) begin
                    if (!dat_corrupt && dat_pid == PID_DATA0) begin
                        wr_valid    = 1'b1;
                        wr_endp     = endp_q;
                        wr_data     = dat_in;
                        hs_pid_d    = PID_ACK;
                        hs_ret_rx_d = 1'b0;
                    end else begin
                        hs_pid_d    = PID_NAK;
                        hs_ret_rx_d = 1'b1;
                    end
                    state_d = TX_HS;
                end else if (timeout) begin
                    err     = 1'b1;
                    state_d = IDLE;
                end
            end

            TX_HS: begin
                tx_valid = 1'b1;
                tx_pid   = hs_pid_q;
                if (tx_ready) begin
                    timer_d = 8'd0;
                    state_d = hs_ret_rx_q ? RX_DATA : IDLE;
                end
            end

            TX_DATA: begin
                tx_valid = 1'b1;
                tx_type  = 1'b1;
                tx_pid   = PID_DATA0;
                tx_data  = payload_q;
                if (tx_ready) begin
                    timer_d = 8'd0;
                    state_d = WAIT_HS;
                end
            end

            WAIT_HS: begin
                // A handshake on the timeout cycle wins; an unrecognised
                // handshake PID is ignored and lets the timeout act.
                if (hs_valid && hs_pid == PID_ACK) begin
                    rd_pop  = 1'b1;
                    state_d = IDLE;
                end else if ((hs_valid && hs_pid == PID_NAK) || timeout) begin
                    if (retry_q == MAX_RETRY) begin
                        err     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        retry_d = retry_q + 4'd1;
                        state_d = TX_DATA;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A reset cycle abandons the transaction, so no decision strobe may
        // escape from it.
        if (rst) begin
            wr_valid = 1'b0;
            wr_endp  = 4'd0;
            wr_data  = 64'd0;
            rd_pop   = 1'b0;
            err      = 1'b0;
        end
    end

endmodule

// File: tb/tb_usb_dev_responder.sv
// Testbench for usb_dev_responder: directed transactions from the test plan
// followed by randomised OUT/IN/filtered transactions, checked against a
// transaction-level model (source FIFO, expected handshakes and payloads).

module tb_usb_dev_responder;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [6:0] DEV_ADDR  = 7'd5;
    localparam int         TIMEOUT   = 255;
    localparam int         MAX_RETRY = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        tok_valid;
    logic [3:0]  tok_pid;
    logic [6:0]  tok_addr;
    logic [3:0]  tok_endp;
    logic        dat_valid;
    logic [3:0]  dat_pid;
    logic        dat_corrupt;
    logic [63:0] dat_in;
    logic        hs_valid;
    logic [3:0]  hs_pid;
    logic        tx_ready;
    logic        tx_valid;
    logic        tx_type;
    logic [3:0]  tx_pid;
    logic [63:0] tx_data;
    logic        wr_valid;
    logic [3:0]  wr_endp;
    logic [63:0] wr_data;
    logic        rd_avail;
    logic [63:0] rd_data;
    logic        rd_pop;
    logic        busy;
    logic        err;

    usb_dev_responder dut (
        .clk         (clk),
        .rst         (rst),
        .tok_valid   (tok_valid),
        .tok_pid     (tok_pid),
        .tok_addr    (tok_addr),
        .tok_endp    (tok_endp),
        .dat_valid   (dat_valid),
        .dat_pid     (dat_pid),
        .dat_corrupt (dat_corrupt),
        .dat_in      (dat_in),
        .hs_valid    (hs_valid),
        .hs_pid      (hs_pid),
        .tx_ready    (tx_ready),
        .tx_valid    (tx_valid),
        .tx_type     (tx_type),
        .tx_pid      (tx_pid),
        .tx_data     (tx_data),
        .wr_valid    (wr_valid),
        .wr_endp     (wr_endp),
        .wr_data     (wr_data),
        .rd_avail    (rd_avail),
        .rd_data     (rd_data),
        .rd_pop      (rd_pop),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations gathered by the monitor on the falling edge.
    int          cyc       = 0;
    logic [68:0] txq[$];
    int          tx_cyc[$];
    logic [67:0] wrq[$];
    int          pop_count = 0;
    int          err_count = 0;
    int          err_cyc   = 0;
    int          idle_viol = 0;
    int          stab_viol = 0;
    logic        prev_stall = 1'b0;
    logic [69:0] prev_pkt   = '0;

    // Source FIFO model feeding rd_avail/rd_data.
    logic [63:0] src[$];

    // Strobe snapshot taken mid-cycle by applyStimulus.
    logic        snap_wr_valid;
    logic [3:0]  snap_wr_endp;
    logic [63:0] snap_wr_data;
    logic        snap_rd_pop;
    logic        snap_err;

    // Passive monitor: logs transfers and strobes, tracks tx field rules.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            txq.push_back({tx_type, tx_pid, tx_data});
            tx_cyc.push_back(cyc);
        end
        if (tx_valid === 1'b0 && {tx_type, tx_pid, tx_data} !== 69'd0)
            idle_viol <= idle_viol + 1;
        if (prev_stall && {tx_valid, tx_type, tx_pid, tx_data} !== prev_pkt)
            stab_viol <= stab_viol + 1;
        prev_stall <= (tx_valid === 1'b1) && (tx_ready !== 1'b1);
        prev_pkt   <= {tx_valid, tx_type, tx_pid, tx_data};
        if (wr_valid === 1'b1) wrq.push_back({wr_endp, wr_data});
        if (rd_pop === 1'b1) pop_count <= pop_count + 1;
        if (err === 1'b1) begin
            err_count <= err_count + 1;
            err_cyc   <= cyc;
        end
    end

    task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    // Drives one cycle of strobe inputs, snapshots the decision strobes.
    task automatic applyStimulus(input logic tv, input logic [3:0] tpid, input logic [6:0] taddr,
                                 input logic [3:0] tendp, input logic dv, input logic [3:0] dpid,
                                 input logic dcor, input logic [63:0] ddata, input logic hv,
                                 input logic [3:0] hpid);
        tok_valid   = tv;
        tok_pid     = tpid;
        tok_addr    = taddr;
        tok_endp    = tendp;
        dat_valid   = dv;
        dat_pid     = dpid;
        dat_corrupt = dcor;
        dat_in      = ddata;
        hs_valid    = hv;
        hs_pid      = hpid;
        @(negedge clk);
        snap_wr_valid = wr_valid;
        snap_wr_endp  = wr_endp;
        snap_wr_data  = wr_data;
        snap_rd_pop   = rd_pop;
        snap_err      = err;
        @(posedge clk);
        #1;
        tok_valid = 1'b0;
        dat_valid = 1'b0;
        hs_valid  = 1'b0;
    endtask

    task automatic sendToken(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp);
        applyStimulus(1'b1, pid, addr, endp, 1'b0, 4'd0, 1'b0, 64'd0, 1'b0, 4'd0);
    endtask

    task automatic sendData(input logic [3:0] pid, input logic cor, input logic [63:0] d);
        applyStimulus(1'b0, 4'd0, 7'd0, 4'd0, 1'b1, pid, cor, d, 1'b0, 4'd0);
    endtask

    task automatic sendHs(input logic [3:0] pid);
        applyStimulus(1'b0, 4'd0, 7'd0, 4'd0, 1'b0, 4'd0, 1'b0, 64'd0, 1'b1, pid);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 7'd0, 4'd0, 1'b0, 4'd0, 1'b0, 64'd0, 1'b0, 4'd0);
    endtask

    task automatic syncSrc();
        rd_avail = (src.size() != 0);
        rd_data  = rd_avail ? src[0] : 64'd0;
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Waits (bounded) for one packet transfer with random backpressure.
    task automatic waitTx(input bit always_ready, output logic [68:0] pkt);
        bit got = 1'b0;
        pkt = '0;
        for (int i = 0; i < 40 && !got; i++) begin
            tx_ready = always_ready ? 1'b1 : ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (tx_valid === 1'b1 && tx_ready) got = 1'b1;
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b0;
        checkOutput("tx_within_budget", 72'(got), 72'd1);
        if (got && txq.size() != 0) pkt = txq.pop_front();
    endtask

    task automatic checkWr(input logic [3:0] endp, input logic [63:0] d);
        checkOutput("wr_event_count", 72'(wrq.size()), 72'd1);
        if (wrq.size() != 0) checkOutput("wr_event_value", 72'(wrq[0]), 72'({endp, d}));
        wrq.delete();
    endtask

    // OUT transaction: nbad rejected data packets, then one good DATA0.
    task automatic doOut(input logic [3:0] endp, input int nbad, input logic [63:0] good);
        logic [68:0] pkt;
        sendToken(PID_OUT, DEV_ADDR, endp);
        checkOutput("out_busy_after_token", 72'(busy), 72'd1);
        checkOutput("out_no_tx_in_rx", 72'(tx_valid), 72'd0);
        if ($urandom_range(0, 1) != 0) begin
            sendToken(PID_IN, DEV_ADDR, endp);
            checkOutput("out_token_ignored", 72'(tx_valid), 72'd0);
        end
        for (int i = 0; i < nbad; i++) begin
            if (i % 2 == 0) sendData(PID_DATA0, 1'b1, rand64());
            else sendData(PID_DATA1, 1'b0, rand64());
            checkOutput("out_bad_no_wr", 72'(snap_wr_valid), 72'd0);
            checkOutput("out_nak_latency", 72'(tx_valid), 72'd1);
            waitTx(1'b0, pkt);
            checkOutput("out_nak_pkt", 72'(pkt), 72'({1'b0, PID_NAK, 64'd0}));
            checkOutput("out_back_to_rx", 72'(busy), 72'd1);
        end
        sendData(PID_DATA0, 1'b0, good);
        checkOutput("out_wr_valid", 72'(snap_wr_valid), 72'd1);
        checkOutput("out_wr_endp", 72'(snap_wr_endp), 72'(endp));
        checkOutput("out_wr_data", 72'(snap_wr_data), 72'(good));
        checkOutput("out_ack_latency", 72'(tx_valid), 72'd1);
        waitTx(1'b0, pkt);
        checkOutput("out_ack_pkt", 72'(pkt), 72'({1'b0, PID_ACK, 64'd0}));
        checkOutput("out_idle_after", 72'(busy), 72'd0);
        checkWr(endp, good);
    endtask

    // IN transaction from a non-empty source: nnak NAKs, then ACK.
    task automatic doIn(input int nnak);
        logic [68:0] pkt;
        logic [63:0] exp_payload;
        int p0, e0;
        exp_payload = src[0];
        p0 = pop_count;
        e0 = err_count;
        sendToken(PID_IN, DEV_ADDR, 4'($urandom_range(0, 15)));
        checkOutput("in_token_latency", 72'(tx_valid), 72'd1);
        for (int r = 0; r <= nnak; r++) begin
            waitTx(1'b0, pkt);
            checkOutput("in_data_pkt", 72'(pkt), 72'({1'b1, PID_DATA0, exp_payload}));
            idle($urandom_range(0, 4));
            if (r < nnak) begin
                sendHs(PID_NAK);
                checkOutput("in_nak_no_pop", 72'(snap_rd_pop), 72'd0);
            end else begin
                sendHs(PID_ACK);
                checkOutput("in_ack_pop", 72'(snap_rd_pop), 72'd1);
            end
        end
        void'(src.pop_front());
        syncSrc();
        checkOutput("in_idle_after", 72'(busy), 72'd0);
        checkOutput("in_pop_once", 72'(pop_count - p0), 72'd1);
        checkOutput("in_no_err", 72'(err_count - e0), 72'd0);
    endtask

    task automatic doInEmpty();
        logic [68:0] pkt;
        sendToken(PID_IN, DEV_ADDR, 4'($urandom_range(0, 15)));
        checkOutput("inempty_latency", 72'(tx_valid), 72'd1);
        waitTx(1'b0, pkt);
        checkOutput("inempty_nak_pkt", 72'(pkt), 72'({1'b0, PID_NAK, 64'd0}));
        checkOutput("inempty_idle_after", 72'(busy), 72'd0);
    endtask

    task automatic doBadAddr(input logic [6:0] addr, input logic [3:0] pid);
        sendToken(pid, addr, 4'($urandom_range(0, 15)));
        checkOutput("filter_not_busy", 72'(busy), 72'd0);
        idle(2);
        checkOutput("filter_no_tx", 72'(tx_valid), 72'd0);
        checkOutput("filter_no_transfer", 72'(txq.size()), 72'd0);
    endtask

    initial begin
        logic [68:0] pkt;
        logic [63:0] d;
        int p0, e0, n0, bad;

        rst = 1'b1;
        tx_ready = 1'b0;
        tok_valid = 1'b0; tok_pid = 4'd0; tok_addr = 7'd0; tok_endp = 4'd0;
        dat_valid = 1'b0; dat_pid = 4'd0; dat_corrupt = 1'b0; dat_in = 64'd0;
        hs_valid = 1'b0; hs_pid = 4'd0;
        syncSrc();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_tx_valid", 72'(tx_valid), 72'd0);
        checkOutput("reset_tx_fields", 72'({tx_type, tx_pid, tx_data}), 72'd0);
        checkOutput("reset_busy", 72'(busy), 72'd0);
        checkOutput("reset_strobes", 72'({wr_valid, rd_pop, err}), 72'd0);
        checkOutput("reset_wr_fields", 72'({wr_endp, wr_data}), 72'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] OUT good / corrupt-then-good");
        doOut(4'd3, 0, 64'hAABBCCDD);
        doOut(4'($urandom_range(0, 15)), 1, 64'h1234);

        $display("[TB] IN with two NAKs");
        src.push_back(64'hDEAD);
        syncSrc();
        doIn(2);

        $display("[TB] IN retry exhaustion");
        src.push_back(rand64());
        syncSrc();
        d  = src[0];
        p0 = pop_count;
        e0 = err_count;
        n0 = tx_cyc.size();
        txq.delete();
        tx_ready = 1'b1;
        sendToken(PID_IN, DEV_ADDR, 4'd1);
        for (int i = 0; i < (MAX_RETRY + 1) * (TIMEOUT + 2) + 50 && err_count == e0; i++) begin
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b0;
        checkOutput("exh_err_once", 72'(err_count - e0), 72'd1);
        checkOutput("exh_no_pop", 72'(pop_count - p0), 72'd0);
        checkOutput("exh_idle", 72'(busy), 72'd0);
        checkOutput("exh_tx_count", 72'(tx_cyc.size() - n0), 72'(MAX_RETRY + 1));
        if (tx_cyc.size() - n0 == MAX_RETRY + 1) begin
            for (int k = 1; k <= MAX_RETRY; k++)
                checkOutput("exh_spacing", 72'(tx_cyc[n0 + k] - tx_cyc[n0 + k - 1]), 72'(TIMEOUT + 2));
            checkOutput("exh_err_delay", 72'(err_cyc - tx_cyc[n0 + MAX_RETRY]), 72'(TIMEOUT + 1));
        end
        bad = 0;
        foreach (txq[i]) if (txq[i] !== {1'b1, PID_DATA0, d}) bad++;
        checkOutput("exh_payloads", 72'(bad), 72'd0);
        txq.delete();

        $display("[TB] reset during WAIT_HS");
        p0 = pop_count;
        e0 = err_count;
        sendToken(PID_IN, DEV_ADDR, 4'd2);
        waitTx(1'b0, pkt);
        checkOutput("rst_data_pkt", 72'(pkt), 72'({1'b1, PID_DATA0, d}));
        idle(3);
        rst = 1'b1;
        hs_valid = 1'b1;
        hs_pid = PID_ACK;
        @(negedge clk);
        checkOutput("rst_strobes_blocked", 72'({rd_pop, err, wr_valid}), 72'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        hs_valid = 1'b0;
        checkOutput("rst_idle", 72'(busy), 72'd0);
        checkOutput("rst_tx_quiet", 72'({tx_valid, tx_type, tx_pid, tx_data}), 72'd0);
        idle(TIMEOUT + 5);
        checkOutput("rst_no_pop", 72'(pop_count - p0), 72'd0);
        checkOutput("rst_no_err", 72'(err_count - e0), 72'd0);
        checkOutput("rst_no_tx", 72'(txq.size()), 72'd0);
        doIn(0);

        $display("[TB] filtering and backpressure");
        doBadAddr(7'd6, PID_OUT);
        sendToken(PID_IN, DEV_ADDR, 4'd0);
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_hold_valid", 72'(tx_valid), 72'd1);
            checkOutput("bp_hold_pid", 72'({tx_type, tx_pid}), 72'({1'b0, PID_NAK}));
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_sent_6th", 72'(tx_valid), 72'd1);
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        checkOutput("bp_idle_after", 72'(busy), 72'd0);
        checkOutput("bp_one_transfer", 72'(txq.size()), 72'd1);
        txq.delete();

        $display("[TB] timeout boundaries");
        e0 = err_count;
        sendToken(PID_OUT, DEV_ADDR, 4'd7);
        idle(TIMEOUT - 1);
        idle(1);
        checkOutput("rx_timeout_not_early", 72'(snap_err), 72'd0);
        idle(1);
        checkOutput("rx_timeout_fires", 72'(snap_err), 72'd1);
        checkOutput("rx_timeout_idle", 72'(busy), 72'd0);
        checkOutput("rx_timeout_no_wr", 72'(wrq.size()), 72'd0);

        d = rand64();
        sendToken(PID_OUT, DEV_ADDR, 4'd9);
        idle(TIMEOUT);
        sendData(PID_DATA0, 1'b0, d);
        checkOutput("rx_data_wins_err", 72'(snap_err), 72'd0);
        checkOutput("rx_data_wins_wr", 72'(snap_wr_valid), 72'd1);
        waitTx(1'b0, pkt);
        checkOutput("rx_data_wins_ack", 72'(pkt), 72'({1'b0, PID_ACK, 64'd0}));
        checkWr(4'd9, d);

        src.push_back(rand64());
        syncSrc();
        sendToken(PID_IN, DEV_ADDR, 4'd4);
        waitTx(1'b0, pkt);
        checkOutput("hs_wins_data_pkt", 72'(pkt), 72'({1'b1, PID_DATA0, src[0]}));
        idle(TIMEOUT);
        sendHs(PID_ACK);
        checkOutput("hs_wins_pop", 72'(snap_rd_pop), 72'd1);
        checkOutput("hs_wins_err", 72'(snap_err), 72'd0);
        checkOutput("hs_wins_idle", 72'(busy), 72'd0);
        void'(src.pop_front());
        syncSrc();

        $display("[TB] randomised transactions");
        for (int it = 0; it < 16; it++) begin
            case ($urandom_range(0, 3))
                0: doOut(4'($urandom_range(0, 15)), $urandom_range(0, 2), rand64());
                1: begin
                    src.push_back(rand64());
                    syncSrc();
                    doIn($urandom_range(0, 3));
                end
                2: begin
                    if (src.size() == 0) doInEmpty();
                    else doIn(0);
                end
                default: begin
                    logic [6:0] a;
                    a = 7'($urandom_range(0, 127));
                    if (a == DEV_ADDR) a = 7'd6;
                    doBadAddr(a, ($urandom_range(0, 1) != 0) ? PID_IN : PID_OUT);
                end
            endcase
        end

        checkOutput("tx_fields_zero_when_idle", 72'(idle_viol), 72'd0);
        checkOutput("tx_stable_under_backpressure", 72'(stab_viol), 72'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_dev_responder.md
# usb_dev_responder

Device-side USB transaction responder: the far end of the host protocol FSM. It consumes decoded token, data and handshake packets from the device's packet decoder and answers them. For OUT transactions it accepts the DATA0 payload, delivers it to the endpoint sink and returns ACK or NAK. For IN transactions it returns DATA0 from the endpoint source and retries until ACK or retry exhaustion.

## Interface
- DEV_ADDR, 7'd5, device address; tokens for any other address are ignored
- TIMEOUT, 8'd255, cycles to wait for data or handshake before a timeout event
- MAX_RETRY, 4'd8, IN-data retransmissions allowed before abort

Clocking: one clock; reset is synchronous and active-high.

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- tok_valid  in  1  one-cycle strobe: token packet decoded
- tok_pid  in  4  token PID: 4'b0001 OUT, 4'b1001 IN
- tok_addr  in  7  token address
- tok_endp  in  4  token endpoint
- dat_valid  in  1  one-cycle strobe: data packet decoded
- dat_pid  in  4  data PID (4'b0011 DATA0)
- dat_corrupt  in  1  CRC/format error on the current data packet; qualified by dat_valid
- dat_in  in  64  data payload
- hs_valid  in  1  one-cycle strobe: handshake decoded
- hs_pid  in  4  4'b0010 ACK, 4'b1010 NAK
- tx_ready  in  1  encoder can accept a packet
- tx_valid  out  1  packet request to encoder
- tx_type  out  1  0 = handshake, 1 = data packet
- tx_pid  out  4  PID to transmit
- tx_data  out  64  payload; valid when tx_type=1
- wr_valid  out  1  one-cycle strobe: OUT payload delivered
- wr_endp  out  4  endpoint for wr_data
- wr_data  out  64  received payload
- rd_avail  in  1  source has an IN payload
- rd_data  in  64  IN payload at head of source
- rd_pop  out  1  one-cycle strobe: head payload consumed
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle strobe: transaction aborted

## Operation
- States: IDLE, RX_DATA, TX_HS, TX_DATA, WAIT_HS.
- Registers: endp_q (4), payload_q (64), hs_pid_q (4), 8-bit timer, 4-bit retry count, next-state tag for TX_HS.
- IDLE: tok_valid with tok_addr==DEV_ADDR:
  - tok_pid OUT: latch endp_q, clear timer, go to RX_DATA.
  - tok_pid IN with rd_avail=1: latch payload_q=rd_data and endp_q, clear timer and retry count, go to TX_DATA.
  - tok_pid IN with rd_avail=0: hs_pid_q=NAK, go to TX_HS, then return to IDLE.
  - Address mismatch or any other PID: ignored.
- RX_DATA, dat_valid with dat_corrupt=0 and dat_pid=DATA0: pulse wr_valid with wr_data=dat_in and wr_endp=endp_q, hs_pid_q=ACK, go to TX_HS, then return to IDLE.
- RX_DATA, dat_valid with corrupt or non-DATA0 PID: hs_pid_q=NAK, go to TX_HS, then return to RX_DATA with timer cleared. The host resends.
- RX_DATA, timer==TIMEOUT with no dat_valid: pulse err, go to IDLE.
- TX_HS: tx_valid=1, tx_type=0, tx_pid=hs_pid_q. Leaves on the tx_valid&tx_ready cycle.
- TX_DATA: tx_valid=1, tx_type=1, tx_pid=4'b0011, tx_data=payload_q. On transfer, clear timer and go to WAIT_HS.
- WAIT_HS:
  - ACK: pulse rd_pop, go to IDLE.
  - NAK, or timer==TIMEOUT: if retry==MAX_RETRY, pulse err and go to IDLE without rd_pop. Otherwise increment retry and go to TX_DATA.
- Inputs not listed for the current state are ignored, including tok_valid while not in IDLE.
- tx_pid, tx_data and tx_type are 0 whenever tx_valid=0.

## Timing
- Reset: state=IDLE, all counters and registers 0, every output 0.
- Reset asserted mid-transaction aborts the transaction: no rd_pop, no wr_valid, no err.
- All transitions are registered. Outputs are Moore, except wr_valid, rd_pop and err, which are combinational one-cycle strobes on the decision cycle.
- Turnaround latency:
  - Token to tx_valid: 1 cycle, i.e. tx_valid rises the cycle after tok_valid.
  - dat_valid to tx_valid: 1 cycle.
- tx_valid and its fields hold stable until tx_ready. tx_ready sampled high while tx_valid is high means the packet is transferred.
- Timer increments once per cycle in RX_DATA/WAIT_HS and saturates at TIMEOUT. Timeout fires on the cycle timer==TIMEOUT, i.e. TIMEOUT+1 cycles after entry.
- If hs_valid and timeout coincide, the handshake wins. If dat_valid and timeout coincide, the data wins.
- Total IN transmissions before abort: MAX_RETRY+1.

## Test plan
- OUT good: token OUT addr 5 endp 3, then DATA0 dat_in=64'hAABBCCDD, corrupt=0 -> wr_valid one cycle with wr_endp=3 and wr_data=64'hAABBCCDD; tx handshake PID 4'b0010; back to IDLE.
- OUT corrupt then good: first DATA0 corrupt -> NAK (4'b1010), no wr_valid; second DATA0 64'h1234 -> ACK and a single wr_valid.
- IN with retries: rd_avail=1, rd_data=64'hDEAD -> DATA0 carrying 64'hDEAD; host NAKs twice then ACKs -> 3 data transmissions, rd_pop exactly once.
- IN exhaustion: no handshake ever, tx_ready=1 -> 9 DATA0 transmissions spaced TIMEOUT+1 cycles in WAIT_HS, then an err pulse, no rd_pop, busy=0.
- Filtering and backpressure: token addr 6 -> no response. IN with rd_avail=0 and tx_ready low 5 cycles -> NAK held stable 5 cycles and sent on the 6th.
- Reset mid-WAIT_HS: rst=1 for one cycle -> IDLE, all outputs 0, no rd_pop or err.
